// File: rtl/reg_file_reader.sv
// Burst read engine for the reg_file read port.
// Walks a wrapping address range and streams words over valid/ready.
module reg_file_reader #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] start_addr,
    input  logic [W:0]   burst_len,
    output logic [W-1:0] r_addr,
    input  logic [B-1:0] r_data,
    output logic [B-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t       state;
    logic [W-1:0] addr_q;
    logic [W:0]   remaining;
    logic         capture;
    logic         handshake;

    assign r_addr = addr_q;

    // Capture needs a word left and a free (or draining) output slot.
    always_comb begin
        capture   = (remaining != '0) && (!out_valid || out_ready);
        handshake = out_valid && out_ready;
    end

    // Burst FSM with registered stream outputs; done is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            addr_q    <= start_addr;
                            remaining <= burst_len;
                            busy      <= 1'b1;
                            state     <= READ;
                        end else begin
                            // Empty burst: report completion without reading.
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (capture) begin
                        out_data  <= r_data;
                        out_valid <= 1'b1;
                        addr_q    <= addr_q + 1'b1;
                        remaining <= remaining - 1'b1;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                    end
                    // Final word accepted: nothing left to capture.
                    if (remaining == '0 && handshake) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader.
// Stimulus pushes expected words; a negedge monitor pops on each handshake.
module tb_reg_file_reader;

    localparam int B = 8;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] start_addr;
    logic [W:0]   burst_len;
    logic [W-1:0] r_addr;
    logic [B-1:0] r_data;
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    logic [B-1:0] mem [4];
    logic [B-1:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int cyc;
    int d0;

    logic         prev_stall = 1'b0;
    logic [B-1:0] prev_data = '0;

    always #5 clk = ~clk;

    assign r_data = mem[r_addr];

    reg_file_reader #(.B(B), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .burst_len(burst_len),
        .r_addr(r_addr),
        .r_data(r_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; returns cycles taken or flags a timeout.
    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cycles++;
            if (done) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: done timeout got 0 expected 1", name);
    endtask

    // Monitor: scoreboard pops on handshakes, stall stability checks.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0d expected none",
                             out_data);
                end else begin
                    check("word", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        mem[0] = 8'd100;
        mem[1] = 8'd101;
        mem[2] = 8'd110;
        mem[3] = 8'd120;
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        burst_len = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(r_addr), 0);
        check("rst_data", int'(out_data), 0);
        reset = 1'b0;
        step();

        // Scenario 1 + 4: full burst, ignored start mid-burst.
        d0 = done_cnt;
        exp_q.push_back(8'd100);
        exp_q.push_back(8'd101);
        exp_q.push_back(8'd110);
        exp_q.push_back(8'd120);
        start = 1'b1;
        start_addr = 2'd0;
        burst_len = 3'd4;
        step();
        start = 1'b0;
        check("s1_busy", int'(busy), 1);
        check("s1_addr", int'(r_addr), 0);
        check("s1_valid0", int'(out_valid), 0);
        step();
        start = 1'b1;
        start_addr = 2'd2;
        step();
        start = 1'b0;
        cyc = 2;
        begin
            int c;
            wait_done("s1", c);
            cyc += c;
        end
        check("s1_latency", cyc, 5);
        check("s1_busy_end", int'(busy), 0);
        step();
        check("s1_done_pulse", int'(done), 0);
        step();
        step();
        check("s1_done_count", done_cnt - d0, 1);
        check("s1_q_empty", exp_q.size(), 0);

        // Scenario 2: wrap 3 -> 0.
        exp_q.push_back(8'd120);
        exp_q.push_back(8'd100);
        exp_q.push_back(8'd101);
        start = 1'b1;
        start_addr = 2'd3;
        burst_len = 3'd3;
        step();
        start = 1'b0;
        wait_done("s2", cyc);
        check("s2_addr_end", int'(r_addr), 2);
        check("s2_q_empty", exp_q.size(), 0);
        step();

        // Scenario 3: backpressure holds the word and the address.
        exp_q.push_back(8'd101);
        exp_q.push_back(8'd110);
        out_ready = 1'b0;
        start = 1'b1;
        start_addr = 2'd1;
        burst_len = 3'd2;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("s3_hold_valid", int'(out_valid), 1);
            check("s3_hold_data", int'(out_data), 101);
            check("s3_hold_addr", int'(r_addr), 2);
            step();
        end
        out_ready = 1'b1;
        wait_done("s3", cyc);
        check("s3_q_empty", exp_q.size(), 0);
        step();

        // Scenario 5: reset mid-burst drops the pending word.
        start = 1'b1;
        start_addr = 2'd0;
        burst_len = 3'd4;
        step();
        start = 1'b0;
        step();
        check("s5_valid_pre", int'(out_valid), 1);
        reset = 1'b1;
        step();
        check("s5_valid", int'(out_valid), 0);
        check("s5_busy", int'(busy), 0);
        check("s5_done", int'(done), 0);
        check("s5_addr", int'(r_addr), 0);
        reset = 1'b0;
        d0 = done_cnt;
        step();
        step();
        check("s5_no_done", done_cnt - d0, 0);
        exp_q.push_back(8'd110);
        exp_q.push_back(8'd120);
        start = 1'b1;
        start_addr = 2'd2;
        burst_len = 3'd2;
        step();
        start = 1'b0;
        wait_done("s5_restart", cyc);
        check("s5_q_empty", exp_q.size(), 0);
        step();

        // Scenario 6: zero-length burst.
        start = 1'b1;
        burst_len = 3'd0;
        step();
        start = 1'b0;
        check("s6_done", int'(done), 1);
        check("s6_busy", int'(busy), 0);
        check("s6_valid", int'(out_valid), 0);
        step();
        check("s6_done_off", int'(done), 0);
        check("s6_busy_off", int'(busy), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
